// File: rtl/wb_committer_n.sv
// wb_committer_n: retires execution-unit results strictly in dispatch order.
// An order FIFO records which unit each dispatched instruction went to. The
// head entry picks the one unit whose writeback is accepted. Accepted results
// go to the regfile one cycle later. A redirecting result parks the block in
// REDIRECT until pcgen takes the new PC, and that handshake flushes the FIFO.
module wb_committer_n #(
  parameter  int NUM_UNITS   = 4,
  parameter  int XLEN        = 32,
  parameter  int ORDER_DEPTH = 8,
  parameter  int RA_WIDTH    = 5,
  localparam int UID_WIDTH   = $clog2(NUM_UNITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ord_tvalid,
  output logic                          ord_tready,
  input  logic [UID_WIDTH-1:0]          ord_tdata,
  input  logic [NUM_UNITS-1:0]          unit_tvalid,
  output logic [NUM_UNITS-1:0]          unit_tready,
  input  logic [NUM_UNITS*RA_WIDTH-1:0] unit_rd,
  input  logic [NUM_UNITS*XLEN-1:0]     unit_wdata,
  input  logic [NUM_UNITS-1:0]          unit_redirect,
  input  logic [NUM_UNITS*XLEN-1:0]     unit_target,
  output logic                          wbrf_valid,
  output logic [RA_WIDTH-1:0]           wbrf_rd,
  output logic [XLEN-1:0]               wbrf_wdata,
  output logic                          wbpcg_tvalid,
  input  logic                          wbpcg_tready,
  output logic [XLEN-1:0]               wbpcg_tdata,
  output logic                          invalidate,
  output logic                          retire
);

  localparam int PTR_WIDTH = $clog2(ORDER_DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(ORDER_DEPTH);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [UID_WIDTH-1:0] r_order [ORDER_DEPTH];
  logic [PTR_WIDTH-1:0] r_rdPtr;
  logic [PTR_WIDTH-1:0] r_wrPtr;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_live;

  logic                 r_wbValid;
  logic                 r_retire;
  logic [RA_WIDTH-1:0]  r_wbRd;
  logic [XLEN-1:0]      r_wbData;
  logic [XLEN-1:0]      r_target;

  logic [UID_WIDTH-1:0] w_head;
  logic                 w_headValid;
  logic                 w_headRedirect;
  logic [RA_WIDTH-1:0]  w_headRd;
  logic [XLEN-1:0]      w_headData;
  logic [XLEN-1:0]      w_headTarget;
  logic                 w_canCommit;
  logic                 w_commit;
  logic                 w_push;
  logic                 w_flush;

  // r_live keeps ord_tready low while reset is held and for the first edge after it.
  assign w_head       = r_order[r_rdPtr];
  assign w_canCommit  = (r_state == IDLE) && (r_count != '0);
  assign w_commit     = w_canCommit && w_headValid;
  assign ord_tready   = r_live && (r_count != FULL_COUNT) && (r_state == IDLE);
  assign w_push       = ord_tvalid && ord_tready;
  assign wbpcg_tvalid = (r_state == REDIRECT);
  assign w_flush      = wbpcg_tvalid && wbpcg_tready;
  assign invalidate   = w_flush;

  assign wbrf_valid  = r_wbValid;
  assign wbrf_rd     = r_wbRd;
  assign wbrf_wdata  = r_wbData;
  assign wbpcg_tdata = r_target;
  assign retire      = r_retire;

  // Select the head unit's result fields and grant tready only to that unit.
  always_comb begin
    w_headValid    = 1'b0;
    w_headRedirect = 1'b0;
    w_headRd       = '0;
    w_headData     = '0;
    w_headTarget   = '0;
    unit_tready    = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (w_head == UID_WIDTH'(u)) begin
        w_headValid    = unit_tvalid[u];
        w_headRedirect = unit_redirect[u];
        w_headRd       = unit_rd[u*RA_WIDTH +: RA_WIDTH];
        w_headData     = unit_wdata[u*XLEN +: XLEN];
        w_headTarget   = unit_target[u*XLEN +: XLEN];
        unit_tready[u] = w_canCommit;
      end
    end
  end

  // State register; reset drops any pending redirect without an invalidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: a redirecting commit parks here until pcgen accepts.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:     if (w_commit && w_headRedirect) w_stateNext = REDIRECT;
      REDIRECT: if (wbpcg_tready)               w_stateNext = IDLE;
      default:  w_stateNext = IDLE;
    endcase
  end

  // Order FIFO: the flush wins over everything else in its cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ORDER_DEPTH; i++) r_order[i] <= '0;
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_order[r_wrPtr] <= ord_tdata;
        r_wrPtr          <= r_wrPtr + 1'b1;
      end
      if (w_commit) r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_commit) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_commit) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Registered writeback, retire pulse and redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wbValid <= 1'b0;
      r_retire  <= 1'b0;
      r_wbRd    <= '0;
      r_wbData  <= '0;
      r_target  <= '0;
    end else begin
      r_wbValid <= w_commit && (w_headRd != '0);
      r_retire  <= w_commit;
      if (w_commit) begin
        r_wbRd   <= w_headRd;
        r_wbData <= w_headData;
      end
      if (w_commit && w_headRedirect) r_target <= w_headTarget;
    end
  end

  // Marks the first clock edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  // The dispatcher must never name a unit that does not exist.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      assert ({1'b0, ord_tdata} < (UID_WIDTH + 1)'(NUM_UNITS));
    end
  end

endmodule

// File: tb/tb_wb_committer_n.sv
// Testbench for wb_committer_n: directed steps, then random traffic, all
// checked against a queue-based model of in-order retirement.
module tb_wb_committer_n;

  localparam int NU  = 4;
  localparam int XL  = 32;
  localparam int OD  = 8;
  localparam int RAW = 5;
  localparam int UW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              ord_tvalid;
  logic              ord_tready;
  logic [UW-1:0]     ord_tdata;
  logic [NU-1:0]     unit_tvalid;
  logic [NU-1:0]     unit_tready;
  logic [NU*RAW-1:0] unit_rd;
  logic [NU*XL-1:0]  unit_wdata;
  logic [NU-1:0]     unit_redirect;
  logic [NU*XL-1:0]  unit_target;
  logic              wbrf_valid;
  logic [RAW-1:0]    wbrf_rd;
  logic [XL-1:0]     wbrf_wdata;
  logic              wbpcg_tvalid;
  logic              wbpcg_tready;
  logic [XL-1:0]     wbpcg_tdata;
  logic              invalidate;
  logic              retire;

  int errors = 0;
  int checks = 0;

  // Reference model state: dispatch-order queue plus expected registered outputs.
  int             ordQ[$];
  bit             mInRedirect;
  bit             mLive;
  logic [XL-1:0]  mTarget;
  bit             mWbValid;
  bit             mRetire;
  logic [RAW-1:0] mRd;
  logic [XL-1:0]  mWdata;

  int wbLog[$];
  int retCount;
  int invCount;

  // Free-running clock, posedge at 5, 15, 25 ...
  always #5 clk = ~clk;

  wb_committer_n #(
    .NUM_UNITS(NU), .XLEN(XL), .ORDER_DEPTH(OD), .RA_WIDTH(RAW)
  ) dut (
    .clk(clk), .rst(rst),
    .ord_tvalid(ord_tvalid), .ord_tready(ord_tready), .ord_tdata(ord_tdata),
    .unit_tvalid(unit_tvalid), .unit_tready(unit_tready), .unit_rd(unit_rd),
    .unit_wdata(unit_wdata), .unit_redirect(unit_redirect), .unit_target(unit_target),
    .wbrf_valid(wbrf_valid), .wbrf_rd(wbrf_rd), .wbrf_wdata(wbrf_wdata),
    .wbpcg_tvalid(wbpcg_tvalid), .wbpcg_tready(wbpcg_tready), .wbpcg_tdata(wbpcg_tdata),
    .invalidate(invalidate), .retire(retire)
  );

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ordValid, input int ordData, input logic pcgReady);
    ord_tvalid   = ordValid;
    ord_tdata    = UW'(ordData);
    wbpcg_tready = pcgReady;
  endtask

  // A unit presents a new result; results already held are never altered.
  task automatic presentResult(input int u, input logic [RAW-1:0] rd, input logic [XL-1:0] data,
                               input logic redir, input logic [XL-1:0] tgt);
    if (!unit_tvalid[u]) begin
      unit_rd[u*RAW +: RAW]  = rd;
      unit_wdata[u*XL +: XL] = data;
      unit_target[u*XL +: XL] = tgt;
      unit_redirect[u]       = redir;
      unit_tvalid[u]         = 1'b1;
    end
  endtask

  task automatic modelReset();
    ordQ.delete();
    mInRedirect = 0;
    mLive       = 0;
    mTarget     = '0;
    mWbValid    = 0;
    mRetire     = 0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0);
    unit_tvalid = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_ord_tready", ord_tready, 0);
    checkOutput("rst_unit_tready", unit_tready, 0);
    checkOutput("rst_wbrf_valid", wbrf_valid, 0);
    checkOutput("rst_retire", retire, 0);
    checkOutput("rst_wbpcg_tvalid", wbpcg_tvalid, 0);
    checkOutput("rst_invalidate", invalidate, 0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic runCycle();
    bit            expOrdReady;
    logic [NU-1:0] expUnitReady;
    bit            commit;
    bit            push;
    bit            flush;
    int            head;
    #2;
    expOrdReady  = mLive && !mInRedirect && (ordQ.size() < OD);
    expUnitReady = '0;
    if (!mInRedirect && ordQ.size() > 0) expUnitReady[ordQ[0]] = 1'b1;
    checkOutput("ord_tready", ord_tready, expOrdReady);
    checkOutput("unit_tready", unit_tready, expUnitReady);
    checkOutput("wbpcg_tvalid", wbpcg_tvalid, mInRedirect);
    if (mInRedirect) checkOutput("wbpcg_tdata", wbpcg_tdata, mTarget);
    checkOutput("invalidate", invalidate, mInRedirect && wbpcg_tready);
    if (invalidate) invCount++;

    flush  = mInRedirect && wbpcg_tready;
    head   = (ordQ.size() > 0) ? ordQ[0] : 0;
    commit = !mInRedirect && (ordQ.size() > 0) && unit_tvalid[head];
    push   = ord_tvalid && expOrdReady;
    mRetire  = commit;
    mWbValid = commit && (unit_rd[head*RAW +: RAW] != '0);
    if (commit) begin
      mRd    = unit_rd[head*RAW +: RAW];
      mWdata = unit_wdata[head*XL +: XL];
      void'(ordQ.pop_front());
      if (unit_redirect[head]) begin
        mInRedirect = 1;
        mTarget     = unit_target[head*XL +: XL];
      end
    end
    if (push) ordQ.push_back(int'(ord_tdata));
    if (flush) begin
      ordQ.delete();
      mInRedirect = 0;
    end
    mLive = 1;

    @(posedge clk);
    #1;
    checkOutput("wbrf_valid", wbrf_valid, mWbValid);
    checkOutput("retire", retire, mRetire);
    if (mWbValid) begin
      checkOutput("wbrf_rd", wbrf_rd, mRd);
      checkOutput("wbrf_wdata", wbrf_wdata, mWdata);
    end
    if (wbrf_valid) wbLog.push_back(int'(wbrf_rd));
    if (retire) retCount++;
    if (commit) unit_tvalid[head] = 1'b0;
    if (flush)  unit_tvalid = '0;
    @(negedge clk);
  endtask

  task automatic presentHead();
    if (ordQ.size() > 0)
      presentResult(ordQ[0], RAW'($urandom_range(0, 31)), $urandom, 1'b0, '0);
  endtask

  // Directed steps followed by a randomized run.
  initial begin
    rst = 1'b1;
    ord_tvalid = 0; ord_tdata = '0; wbpcg_tready = 0;
    unit_tvalid = '0; unit_rd = '0; unit_wdata = '0; unit_redirect = '0; unit_target = '0;
    retCount = 0; invCount = 0;
    modelReset();

    // Reset release with all units valid but nothing dispatched.
    applyReset();
    for (int u = 0; u < NU; u++) presentResult(u, RAW'(u + 1), 32'h100 + u, 1'b0, '0);
    runCycle();
    runCycle();
    unit_tvalid = '0;

    // Dispatch 2,0,1; results arrive 1,0,2 but retire in dispatch order.
    wbLog.delete();
    retCount = 0;
    applyStimulus(1, 2, 0); runCycle();
    applyStimulus(1, 0, 0); runCycle();
    applyStimulus(1, 1, 0); runCycle();
    applyStimulus(0, 0, 0);
    presentResult(1, 5'd6, 32'h22, 1'b0, '0); runCycle();
    presentResult(0, 5'd5, 32'h11, 1'b0, '0); runCycle();
    presentResult(2, 5'd7, 32'h33, 1'b0, '0); runCycle();
    runCycle();
    runCycle();
    runCycle();
    checkOutput("order_wb_count", wbLog.size(), 3);
    if (wbLog.size() == 3) begin
      checkOutput("order_wb0", wbLog[0], 7);
      checkOutput("order_wb1", wbLog[1], 5);
      checkOutput("order_wb2", wbLog[2], 6);
    end
    checkOutput("order_retires", retCount, 3);

    // Fill the FIFO, pop once, then sustained push/pop to wrap the pointers.
    for (int i = 0; i < OD; i++) begin
      applyStimulus(1, $urandom_range(0, NU - 1), 0);
      runCycle();
    end
    applyStimulus(1, 1, 0);
    runCycle();
    presentHead();
    runCycle();
    runCycle();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, $urandom_range(0, NU - 1), 0);
      presentHead();
      runCycle();
    end
    applyStimulus(0, 0, 0);
    for (int k = 0; k < 3 * OD && ordQ.size() > 0; k++) begin
      presentHead();
      runCycle();
    end
    checkOutput("drain_unit_tready", unit_tready, 0);

    // Redirect from unit 3 with pcgen stalling for three cycles.
    invCount = 0;
    applyStimulus(1, 3, 0); runCycle();
    applyStimulus(1, 1, 0); runCycle();
    applyStimulus(0, 0, 0);
    presentResult(1, 5'd9, 32'h99, 1'b0, '0);
    presentResult(3, 5'd1, 32'h1234, 1'b1, 32'h8000_0100);
    runCycle();
    repeat (3) runCycle();
    checkOutput("redir_tdata", wbpcg_tdata, 32'h8000_0100);
    applyStimulus(0, 0, 1); runCycle();
    applyStimulus(0, 0, 0); runCycle();
    runCycle();
    checkOutput("redir_inv_pulses", invCount, 1);

    // Commit to x0 retires without a regfile write.
    applyStimulus(1, 0, 0); runCycle();
    applyStimulus(0, 0, 0);
    presentResult(0, 5'd0, 32'hDEAD, 1'b0, '0);
    runCycle();
    checkOutput("x0_retire", retire, 1);
    checkOutput("x0_wbrf_valid", wbrf_valid, 0);
    runCycle();

    // Reset asserted while a redirect is pending.
    invCount = 0;
    applyStimulus(1, 2, 0); runCycle();
    applyStimulus(0, 0, 0);
    presentResult(2, 5'd3, 32'h5, 1'b1, 32'hCAFE_0000);
    runCycle();
    checkOutput("pre_rst_wbpcg_tvalid", wbpcg_tvalid, 1);
    rst = 1'b1;
    wbpcg_tready = 1'b1;
    #1;
    checkOutput("async_rst_wbpcg_tvalid", wbpcg_tvalid, 0);
    checkOutput("async_rst_invalidate", invalidate, 0);
    applyReset();
    for (int u = 0; u < NU; u++) presentResult(u, RAW'(u + 8), 32'h200 + u, 1'b0, '0);
    runCycle();
    runCycle();
    checkOutput("post_rst_inv_pulses", invCount, 0);

    // Random traffic: dispatches, unit results, redirects and pcgen stalls.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 1) == 1), $urandom_range(0, NU - 1),
                    ($urandom_range(0, 2) != 0));
      for (int u = 0; u < NU; u++) begin
        if ($urandom_range(0, 2) == 0)
          presentResult(u, RAW'($urandom_range(0, 31)), $urandom,
                        ($urandom_range(0, 9) == 0), $urandom);
      end
      runCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_committer_n.md
Name: wb_committer_n

Overview:
- Parametrised successor to the fixed four-unit committer. Retires results from NUM_UNITS execution units strictly in dispatch order.
- An order FIFO, fed by the dispatcher's exwb channel, records the issuing unit of each instruction.
- The head entry selects which unit's writeback is accepted.
- Results drive the regfile write port. Branch/trap redirects drive pcgen and generate the pipeline-wide invalidate.

Parameters:
- NUM_UNITS, 4, number of execution-unit writeback channels (2..8)
- XLEN, 32, data/PC width
- ORDER_DEPTH, 8, order FIFO entries (power of 2, >=2)
- RA_WIDTH, 5, register address width
- UID_WIDTH, $clog2(NUM_UNITS), unit id width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ord_tvalid  in  1  dispatch-order entry valid
- ord_tready  out  1  order FIFO can accept
- ord_tdata  in  UID_WIDTH  unit id of the dispatched instruction
- unit_tvalid  in  NUM_UNITS  per-unit result valid
- unit_tready  out  NUM_UNITS  per-unit result accepted
- unit_rd  in  NUM_UNITS*RA_WIDTH  destination register per unit
- unit_wdata  in  NUM_UNITS*XLEN  result data per unit
- unit_redirect  in  NUM_UNITS  result requires PC redirect
- unit_target  in  NUM_UNITS*XLEN  redirect target per unit
- wbrf_valid  out  1  regfile write strobe (no backpressure)
- wbrf_rd  out  RA_WIDTH  regfile write address
- wbrf_wdata  out  XLEN  regfile write data
- wbpcg_tvalid  out  1  redirect valid to pcgen
- wbpcg_tready  in  1  pcgen accepts redirect
- wbpcg_tdata  out  XLEN  redirect target
- invalidate  out  1  flush pulse, equals wbpcg_tvalid & wbpcg_tready
- retire  out  1  one-cycle pulse per retired instruction (CSR instret)

Behaviour:
- Reset: FIFO empty (rd/wr pointers 0, count 0), state IDLE. All outputs 0: wbrf_*, wbpcg_*, retire, unit_tready; ord_tready=1 one cycle after rst deasserts.
- Order FIFO:
  - ord_tready = (count != ORDER_DEPTH) & state==IDLE.
  - Push on ord handshake. Pointers wrap modulo ORDER_DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - ord_tdata >= NUM_UNITS is an illegal dispatcher output; it is covered by a simulation assertion, behaviour undefined.
- Commit:
  - Only in IDLE with FIFO non-empty. head = entry at rd pointer.
  - unit_tready[head] = 1; all other unit_tready bits = 0.
  - Commit occurs when unit_tvalid[head] is high; this pops the FIFO.
- Writeback (registered, 1-cycle latency):
  - Commit at cycle t gives wbrf_valid=1 at t+1 with the latched rd/wdata, and retire=1 at t+1.
  - wbrf_valid is suppressed when rd==0; retire still pulses.
- States: IDLE, REDIRECT.
  - IDLE -> REDIRECT: a commit with unit_redirect[head]=1. The target is latched into wbpcg_tdata and wbpcg_tvalid=1 from t+1.
  - REDIRECT holds wbpcg_tvalid/tdata stable until wbpcg_tready. No commits and no pushes occur in REDIRECT.
  - On the wbpcg handshake: invalidate=1 for that cycle, FIFO flushed (pointers and count cleared at the next edge), wbpcg_tvalid cleared, return to IDLE.
- The redirecting instruction itself retires. Its rd write, if non-zero, is performed normally at t+1.
- Non-head unit results are held by their units (tready=0); on invalidate the units discard them.
- Simultaneous events: the flush clears the FIFO and overrides any push in the same cycle; pushes are also blocked there by ord_tready=0.
- Reset mid-operation: returns to the reset state immediately (async). A pending redirect is dropped and invalidate is not asserted.

Test Plan:
- Reset release, empty FIFO, unit_tvalid=4'b1111 -> unit_tready=0, wbrf_valid=0, retire=0, ord_tready=1.
- Push ids 2,0,1. Units present results in order 1,0,2 with rd=5/6/7 and wdata=0x11/0x22/0x33 -> writebacks occur in order rd7=0x33, rd5=0x11, rd6=0x22. Each appears 1 cycle after its handshake, with 3 retire pulses.
- Fill the FIFO with ORDER_DEPTH=8 entries -> ord_tready=0. One commit -> ord_tready=1 next cycle. Perform 20 push/pop cycles -> pointer wrap, no entry lost.
- Head unit 3 with redirect=1, target=0x80000100, rd=1, wbpcg_tready held low 3 cycles -> wbpcg_tvalid stable with tdata=0x80000100. On ready: invalidate pulses once, FIFO count 0, and rd1 is written.
- Commit with rd=0 and wdata=0xDEAD -> wbrf_valid stays 0, retire=1.
- Assert rst while in REDIRECT -> wbpcg_tvalid=0 immediately, invalidate never pulses, FIFO empty after release.
